// File: rtl/cmd_collector_pkg.sv
// -----------------------------------------------------------------------------
// usertype : shared types for the Lab10 bookkeeping front end.
//   Action / Formula_Type / Mode / Date / Data_No / Index : field types
//   Data    : 72-bit pattern bus, viewed per field (element [0] = low bits)
//   Cmd_Pkt : assembled command handed to the core FSM
//   ST_*    : collector state encodings, shared with cmd_proto_chk
// -----------------------------------------------------------------------------
package usertype;

   typedef enum logic [1:0] {
      Index_Check      = 2'd0,
      Update           = 2'd1,
      Check_Valid_Date = 2'd2
   } Action;

   typedef enum logic [2:0] {
      Formula_A = 3'h0, Formula_B = 3'h1, Formula_C = 3'h2, Formula_D = 3'h3,
      Formula_E = 3'h4, Formula_F = 3'h5, Formula_G = 3'h6, Formula_H = 3'h7
   } Formula_Type;

   typedef enum logic [1:0] {
      Insensitive = 2'b00,
      Normal      = 2'b01,
      Sensitive   = 2'b11
   } Mode;

   typedef struct packed {
      logic [3:0] M;
      logic [4:0] D;
   } Date;

   typedef logic [7:0]  Data_No;
   typedef logic [11:0] Index;

   typedef union packed {
      Action       [35:0] d_act;
      Formula_Type [23:0] d_formula;
      Mode         [35:0] d_mode;
      Date         [7:0]  d_date;
      Data_No      [8:0]  d_data_no;
      Index        [5:0]  d_index;
   } Data;

   typedef struct packed {
      Action       act;
      Formula_Type formula;
      Mode         mode;
      Date         date;
      Data_No      data_no;
      Index [3:0]  idx;
   } Cmd_Pkt;

   // Encodings of the collector FSM; the checker decodes the state from these.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_W_FORM = 3'd1;
   localparam logic [2:0] ST_W_MODE = 3'd2;
   localparam logic [2:0] ST_W_DATE = 3'd3;
   localparam logic [2:0] ST_W_NO   = 3'd4;
   localparam logic [2:0] ST_W_IDX  = 3'd5;
   localparam logic [2:0] ST_HOLD   = 3'd6;

endpackage

// File: rtl/cmd_collector_proto_chk.sv
// -----------------------------------------------------------------------------
// cmd_proto_chk : combinational protocol-violation detector for cmd_collector.
// Only exists when CMD_PROTO_CHECK_EN is defined.
//   state            in  current collector state (ST_* encoding)
//   act              in  action value on the bus this cycle
//   *_valid          in  field strobes
//   cmd_ready        in  core ready (makes an action strobe legal in HOLD)
//   viol             out violation this cycle
// -----------------------------------------------------------------------------
`ifdef CMD_PROTO_CHECK_EN
module cmd_proto_chk
   import usertype::*;
(
   input  logic [2:0] state,
   input  Action      act,
   input  logic       sel_action_valid,
   input  logic       formula_valid,
   input  logic       mode_valid,
   input  logic       date_valid,
   input  logic       data_no_valid,
   input  logic       index_valid,
   input  logic       cmd_ready,
   output logic       viol
);
   logic [5:0] strobes;
   logic [5:0] allowed;
   logic       multi;
   logic       stray;
   logic       bad_act;

   always_comb begin
      strobes = {sel_action_valid, formula_valid, mode_valid,
                 date_valid, data_no_valid, index_valid};
      allowed = 6'b000000;
      case (state)
         ST_IDLE:   allowed = 6'b100000;
         ST_W_FORM: allowed = 6'b010000;
         ST_W_MODE: allowed = 6'b001000;
         ST_W_DATE: allowed = 6'b000100;
         ST_W_NO:   allowed = 6'b000010;
         ST_W_IDX:  allowed = 6'b000001;
         // Only the handshake cycle may carry a new action.
         ST_HOLD:   allowed = cmd_ready ? 6'b100000 : 6'b000000;
         default:   allowed = 6'b000000;
      endcase
      multi   = (strobes & (strobes - 6'd1)) != 6'd0;
      stray   = (strobes & ~allowed) != 6'd0;
      bad_act = sel_action_valid && allowed[5] && (2'(act) == 2'b11);
      viol    = multi || stray || bad_act;
   end
endmodule
`endif

// File: rtl/cmd_collector.sv
// -----------------------------------------------------------------------------
// cmd_collector : assembles per-field strobes from the 72-bit D bus into one
// Cmd_Pkt and presents it to the core with a valid/ready handshake.
//   clk, rst_n         clock, asynchronous active-low reset
//   *_valid            field strobes (one field per strobe)
//   D                  shared data bus; each field taken from its low slice
//   cmd_ready          core accepts the packet
//   cmd_valid, cmd     packet output, held stable in HOLD
//   proto_err          one-cycle violation pulse (0 without the checker)
// Optional feature: CMD_PROTO_CHECK_EN enables cmd_proto_chk.
// -----------------------------------------------------------------------------
module cmd_collector
   import usertype::*;
#(
   parameter int IDX_NUM = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   sel_action_valid,
   input  logic   formula_valid,
   input  logic   mode_valid,
   input  logic   date_valid,
   input  logic   data_no_valid,
   input  logic   index_valid,
   input  Data    D,
   input  logic   cmd_ready,
   output logic   cmd_valid,
   output Cmd_Pkt cmd,
   output logic   proto_err
);
   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      W_FORM = ST_W_FORM,
      W_MODE = ST_W_MODE,
      W_DATE = ST_W_DATE,
      W_NO   = ST_W_NO,
      W_IDX  = ST_W_IDX,
      HOLD   = ST_HOLD
   } state_t;

   state_t     state_reg, state_next;
   Cmd_Pkt     pkt_reg, pkt_next;
   logic [1:0] idx_cnt_reg, idx_cnt_next;
   logic       viol;
   logic       d_unused;

   // Only bits [11:0] of the bus ever carry a field.
   assign d_unused = ^D[71:12];

`ifdef CMD_PROTO_CHECK_EN
   logic proto_err_reg;

   cmd_proto_chk u_chk (
      .state            (state_reg),
      .act              (D.d_act[0]),
      .sel_action_valid (sel_action_valid),
      .formula_valid    (formula_valid),
      .mode_valid       (mode_valid),
      .date_valid       (date_valid),
      .data_no_valid    (data_no_valid),
      .index_valid      (index_valid),
      .cmd_ready        (cmd_ready),
      .viol             (viol)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) proto_err_reg <= 1'b0;
      else        proto_err_reg <= viol;
   end
   assign proto_err = proto_err_reg;
`else
   assign viol      = 1'b0;
   assign proto_err = 1'b0;
`endif

   always_comb begin
      state_next   = state_reg;
      pkt_next     = pkt_reg;
      idx_cnt_next = idx_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (sel_action_valid) begin
               pkt_next     = '0;
               pkt_next.act = D.d_act[0];
               state_next   = (D.d_act[0] == Index_Check) ? W_FORM : W_DATE;
            end
         end
         W_FORM: begin
            if (formula_valid) begin
               pkt_next.formula = D.d_formula[0];
               state_next       = W_MODE;
            end
         end
         W_MODE: begin
            if (mode_valid) begin
               pkt_next.mode = D.d_mode[0];
               state_next    = W_DATE;
            end
         end
         W_DATE: begin
            if (date_valid) begin
               pkt_next.date = D.d_date[0];
               state_next    = W_NO;
            end
         end
         W_NO: begin
            if (data_no_valid) begin
               pkt_next.data_no = D.d_data_no[0];
               // Action 2'b11 falls through to the short (date-only) sequence.
               state_next = (pkt_reg.act == Index_Check || pkt_reg.act == Update)
                            ? W_IDX : HOLD;
            end
         end
         W_IDX: begin
            if (index_valid) begin
               pkt_next.idx[idx_cnt_reg] = D.d_index[0];
               if (idx_cnt_reg == 2'(IDX_NUM - 1)) begin
                  idx_cnt_next = 2'd0;
                  state_next   = HOLD;
               end else begin
                  idx_cnt_next = idx_cnt_reg + 2'd1;
               end
            end
         end
         HOLD: begin
            if (cmd_ready) begin
               // Back-to-back: a new action in the handshake cycle starts the next packet.
               if (sel_action_valid) begin
                  pkt_next     = '0;
                  pkt_next.act = D.d_act[0];
                  state_next   = (D.d_act[0] == Index_Check) ? W_FORM : W_DATE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // A violation drops any partial packet; a HOLD packet still waiting for
      // the core is left untouched and only flagged.
      if (viol && !(state_reg == HOLD && !cmd_ready)) begin
         state_next   = IDLE;
         pkt_next     = pkt_reg;
         idx_cnt_next = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         pkt_reg     <= '0;
         idx_cnt_reg <= 2'd0;
      end else begin
         state_reg   <= state_next;
         pkt_reg     <= pkt_next;
         idx_cnt_reg <= idx_cnt_next;
      end
   end

   assign cmd_valid = (state_reg == HOLD);
   assign cmd       = pkt_reg;

endmodule
